// File: rtl/imc_wrapper_pkg.sv
// Shared definitions for the IMC input/output wrappers: FSM states and word-count sizing.
package imc_wrapper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_WORDS = 4;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

endpackage

// File: rtl/out_wrapper_controller.sv
// Output-wrapper control: IDLE/SEND/DONE sequencing, word counter and handshake pulses.
module out_wrapper_controller
    import imc_wrapper_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             imc_done,
    input  logic             data_accept,
    output logic             capture,
    output logic [CNT_W-1:0] word_cnt,
    output logic             wrap_ready,
    output logic             imc_ack,
    output logic             data_ready,
    output logic             done,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ack_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            imc_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_cnt <= cnt_nxt;
            imc_ack  <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = word_cnt;
        ack_nxt    = 1'b0;
        capture    = 1'b0;
        wrap_ready = 1'b0;
        data_ready = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                wrap_ready = 1'b1;
                busy       = 1'b0;
                if (imc_done) begin
                    capture   = 1'b1;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                data_ready = 1'b1;
                // The fourth transfer leaves SEND, so the 2-bit counter never wraps mid-frame.
                if (data_accept) begin
                    cnt_nxt = word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/out_wrapper.sv
// Output wrapper: captures four IMC result words and streams them one per accepted transfer.
module out_wrapper
    import imc_wrapper_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imc_done_i,
    input  logic [4*DATA_W-1:0]   imc_res_i,
    output logic                  wrap_ready_o,
    output logic                  imc_ack_o,
    output logic [DATA_W-1:0]     data_o,
    output logic                  data_ready_o,
    input  logic                  data_accept_i,
    output logic                  done_o,
    output logic                  busy_o
);

    logic              capture;
    logic [CNT_W-1:0]  word_cnt;
    logic [DATA_W-1:0] buffer [NUM_WORDS];

    out_wrapper_controller u_ctrl (
        .clk         (clk_i),
        .rst         (rst_i),
        .imc_done    (imc_done_i),
        .data_accept (data_accept_i),
        .capture     (capture),
        .word_cnt    (word_cnt),
        .wrap_ready  (wrap_ready_o),
        .imc_ack     (imc_ack_o),
        .data_ready  (data_ready_o),
        .done        (done_o),
        .busy        (busy_o)
    );

    // Result words are held locally so the IMC may change imc_res_i once acked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buffer[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buffer[i] <= imc_res_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign data_o = data_ready_o ? buffer[word_cnt] : '0;

endmodule
